// File: rtl/dff_bank_write_arbiter.sv
// dff_bank_write_arbiter: round-robin write arbiter for one shared register, with a hold window after every write
module dff_bank_write_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    localparam int IW = $clog2(N_REQ),
    localparam int CW = $clog2(HOLD_CYCLES + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic                   busy,
    output logic [IW-1:0]          last_id
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] win;
    logic          any;
    logic [IW-1:0] idx;
    // Scan from ptr upward with wraparound; the first set bit wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            q_valid <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
            last_id <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            gnt <= '0;
            if (state == IDLE) begin
                if (any) begin
                    q       <= d_in[win*WIDTH +: WIDTH];
                    gnt     <= N_REQ'(1) << win;
                    q_valid <= 1'b1;
                    last_id <= win;
                    ptr     <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state <= HOLD;
                        cnt   <= CW'(HOLD_CYCLES);
                        busy  <= 1'b1;
                    end
                end
            end else begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/dff_bank_write_arbiter.md
Name: dff_bank_write_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among N_REQ requesters. It owns the register's write enable and data mux, grants one requester per write, and captures the winner's data. After each write it enforces a programmable hold window in which no new write is accepted. It sits between the requester blocks and the shared register; q is the register output.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, width of the shared register
HOLD_CYCLES, 2, idle cycles forced after every write (>=0; 0 allows a write every cycle)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester write request, level, held until granted
d_in  input  N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
gnt  output  N_REQ  registered one-hot grant, 1-cycle pulse; data captured on the same edge
q  output  WIDTH  shared register contents
q_valid  output  1  high once any write has occurred since reset
busy  output  1  high during the hold window
last_id  output  $clog2(N_REQ)  index of the most recent grantee

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No other clocks or async paths.
- Reset (rst=1 at a rising edge): state=IDLE, q=0, q_valid=0, gnt=0, busy=0, last_id=0, round-robin pointer ptr=0, hold counter=0. rst has priority over all other inputs.
- FSM states: IDLE, HOLD.
- IDLE with req==0: stay in IDLE; gnt=0.
- IDLE with req!=0 at edge t:
  - Winner w = first set req bit searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
  - At edge t: q<=d_in lane w, gnt<=one-hot(w), q_valid<=1, last_id<=w, ptr<=(w+1) mod N_REQ.
  - If HOLD_CYCLES>0: state<=HOLD, counter<=HOLD_CYCLES, busy<=1. Otherwise stay in IDLE.
- Latency: req sampled high in IDLE gives gnt high and q updated in the very next cycle.
- HOLD:
  - gnt=0 and busy=1 for exactly HOLD_CYCLES cycles; counter decrements each cycle.
  - When counter==1: state<=IDLE, busy<=0.
  - req is ignored, not queued, and is re-evaluated on the first IDLE cycle.
  - Minimum spacing between gnt pulses is HOLD_CYCLES+1 cycles.
- Requester protocol: keep req and d_in stable until gnt is seen. Dropping req before grant cancels the request with no side effects. After gnt, the requester deasserts req the cycle gnt is seen or it is treated as a new request.
- q holds its value between writes; only a grant or rst changes it.
- Reset mid-HOLD: hold aborted; next cycle state=IDLE, busy=0, q=0, ptr=0.
- gnt is always zero or one-hot. gnt, busy, q, q_valid and last_id are all registered; there are no combinational input-to-output paths.
- ptr wrap: after a grant to N_REQ-1, ptr=0.

Test Plan:
Defaults for all scenarios: N_REQ=4, WIDTH=8, HOLD_CYCLES=2 unless noted.
1. Reset: rst=1 for 3 cycles with req=4'b1111 and all lanes 8'hFF -> q=0, gnt=0, q_valid=0, busy=0, last_id=0 throughout.
2. Single request: req=4'b0100, lane2=8'hA5 -> next cycle gnt=4'b0100, q=8'hA5, q_valid=1, last_id=2, busy=1 for 2 cycles, then busy=0.
3. Fairness: req=4'b1111 held, lane i data=8'h10+i -> gnt sequence 0001, 0010, 0100, 1000, 0001, pulses every 3 cycles, q=10, 11, 12, 13, 10. With HOLD_CYCLES=0 the same sequence appears on consecutive cycles and busy stays 0.
4. Wrap and skip: after a grant to requester 3, apply req=4'b1001 -> grant 0001; then req=4'b1001 -> grant 1000.
5. Request withdrawn during HOLD: after a grant, assert req=4'b0010 and drop it before HOLD ends -> no gnt, q unchanged.
6. Reset mid-HOLD: rst pulse in first HOLD cycle -> next cycle busy=0, q=0, q_valid=0. Then req=4'b0110 -> gnt=4'b0010 (ptr restarted at 0).
